// File: rtl/dmem_store_buffer_if.sv
// Bundle of stage-side store/load signals and data SRAM port for dmem_store_buffer.
// master = pipeline stage + SRAM environment, slave = the store buffer.
interface dmem_store_buffer_if;
  logic        mem_wr;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic        stall;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_gnt;
  logic [31:0] sram_rdata;

  modport master (
    output mem_wr, mem_w_addr, mem_w_data, rd_en, rd_addr, sram_gnt, sram_rdata,
    input  stall, rd_valid, rd_data, sram_req, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  mem_wr, mem_w_addr, mem_w_data, rd_en, rd_addr, sram_gnt, sram_rdata,
    output stall, rd_valid, rd_data, sram_req, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// FIFO store buffer draining to a single-ported data SRAM, with load servicing.
// Define STORE_FWD_EN for store-to-load forwarding and load-over-drain priority.
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_store_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

  state_t        state;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          full;
  logic          enq;
  logic          pop;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_o;
  logic [31:0]   wdata_o;
  logic          valid_q;
  logic          src_sram;

  assign full      = (count == (PW+1)'(DEPTH));
  assign enq       = bus.mem_wr & ~full;
  assign pop       = (state == DRAIN) & bus.sram_gnt;
  assign bus.stall = bus.mem_wr & full;

  assign bus.sram_req   = req_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_o;
  assign bus.sram_wdata = wdata_o;
  assign bus.rd_valid   = valid_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= bus.mem_w_addr;
      data_q[tail] <= bus.mem_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(pop);
    end
  end

`ifdef STORE_FWD_EN
  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] idx;
  logic [31:0]   fwd_q;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (addr_q[idx][31:2] == bus.rd_addr[31:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign bus.rd_data = src_sram ? bus.sram_rdata : fwd_q;
`else
  assign bus.rd_data = src_sram ? bus.sram_rdata : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      valid_q  <= 1'b0;
      src_sram <= 1'b0;
`ifdef STORE_FWD_EN
      fwd_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef STORE_FWD_EN
          if (bus.rd_en && hit) begin
            state    <= RESP;
            valid_q  <= 1'b1;
            src_sram <= 1'b0;
            fwd_q    <= hit_data;
          end else if (bus.rd_en) begin
            state  <= READ;
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_o <= bus.rd_addr;
          end else if (count != '0) begin
            state   <= DRAIN;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_o  <= addr_q[head];
            wdata_o <= data_q[head];
          end
`else
          // A pending load waits here until every buffered store has drained.
          if (count != '0) begin
            state   <= DRAIN;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_o  <= addr_q[head];
            wdata_o <= data_q[head];
          end else if (bus.rd_en) begin
            state  <= READ;
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_o <= bus.rd_addr;
          end
`endif
        end
        DRAIN: begin
          if (bus.sram_gnt) begin
            state <= IDLE;
            req_q <= 1'b0;
            we_q  <= 1'b0;
          end
        end
        READ: begin
          if (bus.sram_gnt) begin
            state    <= RESP;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            src_sram <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: queue/memory reference model checked every cycle,
// plus literal expectations for stall, drain order, load latency and reset behaviour.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dmem_store_buffer_if bus();

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t         mq[$];
  logic [31:0] sram_mem [logic [29:0]];
  logic [31:0] log_addr[$];
  bit          log_we[$];
  logic        load_pending;
  logic [31:0] ld_addr;
  logic [31:0] rdata_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, event required", name);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return sram_mem.exists(a[31:2]) ? sram_mem[a[31:2]] : 32'h0;
  endfunction

  // Architectural view of a load: youngest buffered store to the word, else SRAM.
  function automatic logic [31:0] exp_load(input logic [31:0] a);
    logic [31:0] v;
    v = mem_rd(a);
    foreach (mq[i]) if (mq[i].addr[31:2] == a[31:2]) v = mq[i].data;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.sram_rdata = rdata_next;
  end

  always @(negedge clk) begin : mon
    bit acc;
    if (!rst_n) begin
      mq.delete();
      rdata_next = 32'hDEAD_BEEF;
    end else begin
      acc = bus.mem_wr && (mq.size() < DEPTH);
      chk("stall", bus.stall, bus.mem_wr && (mq.size() == DEPTH));
      if (bus.sram_req && bus.sram_we) begin
        chk("drain_entry_present", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          chk("drain_addr", bus.sram_addr, mq[0].addr);
          chk("drain_data", bus.sram_wdata, mq[0].data);
        end
      end
      if (bus.sram_req && !bus.sram_we) begin
        chk("read_needs_load", load_pending, 1);
        chk("read_addr", bus.sram_addr, ld_addr);
`ifndef STORE_FWD_EN
        chk("read_after_empty", mq.size(), 0);
`endif
      end
      if (!bus.sram_req) chk("we_without_req", bus.sram_we, 0);
      if (bus.rd_valid) begin
        chk("rd_valid_expected", load_pending, 1);
        chk("rd_data", bus.rd_data, exp_load(ld_addr));
        load_pending = 1'b0;
      end
      // Apply what the coming rising edge will do.
      rdata_next = 32'hDEAD_BEEF;
      if (bus.sram_req && bus.sram_gnt) begin
        log_addr.push_back(bus.sram_addr);
        log_we.push_back(bus.sram_we);
        if (bus.sram_we) begin
          if (mq.size() != 0) begin
            sram_mem[mq[0].addr[31:2]] = mq[0].data;
            void'(mq.pop_front());
          end
        end else begin
          rdata_next = mem_rd(bus.sram_addr);
        end
      end
      if (acc) mq.push_back('{bus.mem_w_addr, bus.mem_w_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    step();
    bus.mem_wr   = 1'b0;
    bus.rd_en    = 1'b0;
    bus.sram_gnt = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mq.size() == 0 && !bus.sram_req) return;
      step();
    end
    fail_now("drain_timeout");
  endtask

  task automatic wait_valid(output int n, output logic [31:0] d);
    n = -1;
    d = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        n = k;
        d = bus.rd_data;
        return;
      end
      step();
    end
    fail_now("rd_valid_timeout");
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_wr     = 1'b1;
    bus.mem_w_addr = a;
    bus.mem_w_data = d;
  endtask

  task automatic load(input logic [31:0] a);
    bus.mem_wr   = 1'b0;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = a;
    ld_addr      = a;
    load_pending = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] d;
    logic [31:0] exp_wrap [5];
    logic [31:0] exp_pp   [5];
    exp_wrap = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    exp_pp   = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410};
    tests = 0;
    fails = 0;
    load_pending   = 1'b0;
    ld_addr        = '0;
    rdata_next     = 32'hDEAD_BEEF;
    sram_mem[30'h80] = 32'h55;
    rst_n          = 1'b0;
    bus.mem_wr     = 1'b1;
    bus.mem_w_addr = '0;
    bus.mem_w_data = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.sram_gnt   = 1'b0;
    bus.sram_rdata = 32'hDEAD_BEEF;

    #3;
    chk("rst_stall", bus.stall, 0);
    chk("rst_sram_req", bus.sram_req, 0);
    chk("rst_sram_we", bus.sram_we, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_sram_wdata", bus.sram_wdata, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    bus.mem_wr = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full buffer, single grant frees one slot, drain order across pointer wrap.
    step();
    log_addr.delete(); log_we.delete();
    bus.sram_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      store(32'h10 * (i + 1), 32'hD0 + i);
      @(negedge clk);
      chk($sformatf("full_stall_%0d", i), bus.stall, (i == 4) ? 1 : 0);
      if (i < 4) step();
    end
    step();
    bus.sram_gnt = 1'b1;
    @(negedge clk);
    chk("full_stall_at_grant", bus.stall, 1);
    step();
    bus.sram_gnt = 1'b0;
    @(negedge clk);
    chk("stall_released", bus.stall, 0);
    drain_all();
    chk("wrap_drain_count", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++)
      chk($sformatf("wrap_order_%0d", i), log_addr[i], exp_wrap[i]);

    // Two stores to one word, then a load of it.
    step();
    log_addr.delete(); log_we.delete();
    bus.sram_gnt = 1'b0;
    store(32'h100, 32'hA);
    step();
    store(32'h100, 32'hB);
    step();
    load(32'h100);
    bus.sram_gnt = 1'b1;
    wait_valid(n, d);
    chk("same_word_data", d, 32'hB);
`ifdef STORE_FWD_EN
    chk("fwd_latency", n, 2);
    chk("fwd_sram_ops", log_addr.size(), 1);
    if (log_we.size() > 0) chk("fwd_no_read", log_we[log_we.size()-1], 1);
`else
    chk("nofwd_latency", n, 5);
    chk("nofwd_sram_ops", log_addr.size(), 3);
    if (log_we.size() == 3) begin
      chk("nofwd_op0_write", log_we[0], 1);
      chk("nofwd_op1_write", log_we[1], 1);
      chk("nofwd_op2_read", log_we[2], 0);
      chk("nofwd_read_addr", log_addr[2], 32'h100);
    end
`endif
    step();
    bus.rd_en = 1'b0;
    drain_all();

    // Load of a word not in the buffer while another store is buffered.
    step();
    log_addr.delete(); log_we.delete();
    bus.sram_gnt = 1'b1;
    store(32'h100, 32'h77);
    step();
    load(32'h200);
    wait_valid(n, d);
    chk("miss_data", d, 32'h55);
`ifdef STORE_FWD_EN
    chk("miss_latency", n, 2);
    if (log_we.size() > 0) begin
      chk("miss_first_is_read", log_we[0], 0);
      chk("miss_first_addr", log_addr[0], 32'h200);
    end
`else
    chk("miss_latency", n, 4);
    if (log_we.size() > 0) begin
      chk("miss_first_is_write", log_we[0], 1);
      chk("miss_first_addr", log_addr[0], 32'h100);
    end
`endif
    step();
    bus.rd_en = 1'b0;
    drain_all();

    // Enqueue coincident with a granted pop at count = DEPTH-1.
    step();
    log_addr.delete(); log_we.delete();
    bus.sram_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h400 + 4 * i, 32'h4000 + i);
      step();
    end
    store(32'h40C, 32'h4003);
    bus.sram_gnt = 1'b1;
    @(negedge clk);
    chk("pushpop_stall", bus.stall, 0);
    step();
    bus.sram_gnt = 1'b0;
    store(32'h410, 32'h4004);
    @(negedge clk);
    chk("pushpop_room_left", bus.stall, 0);
    step();
    store(32'h414, 32'h4005);
    @(negedge clk);
    chk("pushpop_now_full", bus.stall, 1);
    drain_all();
    chk("pushpop_drain_count", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++)
      chk($sformatf("pushpop_order_%0d", i), log_addr[i], exp_pp[i]);

    // Asynchronous reset during an ungranted drain.
    step();
    log_addr.delete(); log_we.delete();
    bus.sram_gnt = 1'b0;
    store(32'h300, 32'h1);
    step();
    store(32'h304, 32'h2);
    step();
    bus.mem_wr = 1'b0;
    @(negedge clk);
    chk("drain_active", bus.sram_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", bus.sram_req, 0);
    chk("rst_async_we", bus.sram_we, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.sram_gnt = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("no_write_after_rst", log_addr.size(), 0);
    step();
    bus.sram_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      store(32'h500 + 4 * i, 32'h50 + i);
      @(negedge clk);
      chk($sformatf("post_rst_stall_%0d", i), bus.stall, (i == 4) ? 1 : 0);
      if (i < 4) step();
    end
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
